// File: rtl/microsequencer.sv
// microsequencer: next-microstate selection and one-entry return register for the control store
module microsequencer #(
  parameter logic [7:0] RESET_STATE   = 8'd0,
  parameter logic [7:0] ILLEGAL_STATE = 8'd63
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] enc_state,
  input  logic [2:0] ns_sel,
  input  logic [1:0] cond_sel,
  input  logic [7:0] cr_addr,
  input  logic       moc,
  input  logic       cond_true,
  input  logic       irq,
  output logic [7:0] state,
  output logic [7:0] ret_state,
  output logic       illegal
);
  logic       c;
  logic       trap;
  logic [7:0] inc;
  logic [7:0] next;
  // condition mux, increment path and next-state selection
  always_comb begin
    c    = cond_sel == 2'd0 ? moc : cond_sel == 2'd1 ? cond_true : cond_sel == 2'd2 ? irq : 1'b1;
    inc  = state + 8'd1;
    trap = ns_sel == 3'd2 && enc_state == 8'd0;
    next = ns_sel == 3'd0 ? inc :
           ns_sel == 3'd1 ? cr_addr :
           ns_sel == 3'd2 ? (trap ? ILLEGAL_STATE : enc_state) :
           ns_sel == 3'd3 ? (c ? cr_addr : inc) :
           ns_sel == 3'd4 ? (c ? inc : cr_addr) :
           ns_sel == 3'd5 ? cr_addr :
           ns_sel == 3'd6 ? ret_state : state;
  end
  // microstate, return register and illegal-decode flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RESET_STATE;
      ret_state <= 8'd0;
      illegal   <= 1'b0;
    end else begin
      state   <= next;
      illegal <= trap;
      if (ns_sel == 3'd5) ret_state <= inc;
    end
  end
endmodule

// File: tb/tb_microsequencer.sv
// tb_microsequencer: directed vectors with hand-computed expectations
module tb_microsequencer;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] enc_state;
  logic [2:0] ns_sel;
  logic [1:0] cond_sel;
  logic [7:0] cr_addr;
  logic       moc;
  logic       cond_true;
  logic       irq;
  logic [7:0] state;
  logic [7:0] ret_state;
  logic       illegal;
  int         errors = 0;
  int         checks = 0;

  microsequencer dut (
    .clk(clk), .reset(reset), .enc_state(enc_state), .ns_sel(ns_sel),
    .cond_sel(cond_sel), .cr_addr(cr_addr), .moc(moc), .cond_true(cond_true),
    .irq(irq), .state(state), .ret_state(ret_state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [2:0] s, input logic [7:0] a);
    ns_sel = s;
    cr_addr = a;
    step();
  endtask

  initial begin
    reset = 1'b1; enc_state = 8'd0; ns_sel = 3'd0; cond_sel = 2'd0;
    cr_addr = 8'd0; moc = 1'b0; cond_true = 1'b0; irq = 1'b0;
    step(); step();
    check("rst_state", state, 8'h00);
    check("rst_ret", ret_state, 8'h00);
    check("rst_illegal", {7'd0, illegal}, 8'h00);
    reset = 1'b0;
    go(3'd0, 8'h00); check("inc1", state, 8'h01);
    go(3'd0, 8'h00); check("inc2", state, 8'h02);
    go(3'd0, 8'h00); check("inc3", state, 8'h03);
    check("inc_ret", ret_state, 8'h00);
    check("inc_illegal", {7'd0, illegal}, 8'h00);
    go(3'd1, 8'h01); check("jump", state, 8'h01);
    enc_state = 8'h22;
    go(3'd2, 8'h00); check("decode", state, 8'h22);
    check("decode_illegal", {7'd0, illegal}, 8'h00);
    enc_state = 8'h00;
    go(3'd2, 8'h00); check("decode_trap", state, 8'd63);
    check("trap_illegal", {7'd0, illegal}, 8'h01);
    go(3'd7, 8'h00); check("hold", state, 8'd63);
    check("illegal_clear", {7'd0, illegal}, 8'h00);
    go(3'd1, 8'h05);
    cond_sel = 2'd1; cond_true = 1'b0;
    go(3'd3, 8'h09); check("brt_not_taken", state, 8'h06);
    cond_true = 1'b1;
    go(3'd3, 8'h09); check("brt_taken", state, 8'h09);
    cond_sel = 2'd3;
    go(3'd4, 8'h50); check("brf_const1", state, 8'h0a);
    cond_sel = 2'd2; irq = 1'b1;
    go(3'd3, 8'h28); check("brt_irq", state, 8'h28);
    irq = 1'b0; cond_sel = 2'd0; moc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      go(3'd4, 8'h28); check("moc_wait", state, 8'h28);
    end
    moc = 1'b1;
    go(3'd4, 8'h28); check("moc_done", state, 8'h29);
    go(3'd5, 8'h29); check("call_self_state", state, 8'h29);
    check("call_self_ret", ret_state, 8'h2a);
    go(3'd1, 8'hff);
    go(3'd5, 8'h40); check("call_wrap_state", state, 8'h40);
    check("call_wrap_ret", ret_state, 8'h00);
    go(3'd6, 8'h77); check("ret", state, 8'h00);
    check("ret_kept", ret_state, 8'h00);
    go(3'd1, 8'hff);
    go(3'd0, 8'h00); check("inc_wrap", state, 8'h00);
    go(3'd5, 8'h10); check("call_state", state, 8'h10);
    check("call_ret", ret_state, 8'h01);
    enc_state = 8'h00;
    go(3'd2, 8'h00);
    reset = 1'b1;
    go(3'd5, 8'h77); check("rst_call_state", state, 8'h00);
    check("rst_call_ret", ret_state, 8'h00);
    check("rst_call_illegal", {7'd0, illegal}, 8'h00);
    reset = 1'b0;
    go(3'd1, 8'h33);
    go(3'd6, 8'h00); check("ret_after_reset", state, 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
